// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite responder backed by a word-organised SRAM.
// Handles byte, halfword and word accesses and inserts WAIT_STATES wait cycles
// into every OKAY data phase.
// Optional feature macro: AHB_SRAM_ERRCHK_EN. When it is defined, illegal accesses
// get a two-cycle ERROR response. When it is undefined, HRESP is always OKAY,
// unaligned lane bits are masked and the offset wraps modulo DEPTH.
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBUST,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic [1:0]  HRESP,
    output logic        HREADY
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

`ifdef AHB_SRAM_ERRCHK_EN
    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;
`else
    typedef enum logic [0:0] {StIdle, StData} state_e;
`endif

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic            hready_q;
    logic [1:0]      hresp_q;
    logic [AW-1:0]   idx_q;
    logic [3:0]      be_q;
    logic            write_q;

    logic [31:0]     mem [DEPTH];

    logic [31:0]     offset;
    logic [1:0]      lane;
    logic [1:0]      lane_eff;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    logic            accept;
    logic            illegal;
    logic            commit;

    // Next-phase values, used by every state in which a data phase can start
    state_e          acc_state;
    logic [3:0]      acc_cnt;
    logic            acc_ready;
    logic [1:0]      acc_resp;

    // Address-phase decode: offset, word index, byte enables, legality
    always_comb begin
        offset   = HADDR - BASE_ADDR;
        lane     = offset[1:0];
        idx      = offset[AW+1:2];
        accept   = HSEL && HTRANS[1] && hready_q;
        illegal  = 1'b0;
        lane_eff = lane;
`ifdef AHB_SRAM_ERRCHK_EN
        if (HSIZE > 3'b010) illegal = 1'b1;
        if (HSIZE == 3'b001 && lane[0]) illegal = 1'b1;
        if (HSIZE == 3'b010 && lane != 2'b00) illegal = 1'b1;
        // Any upper offset bit set means the access lies outside the window
        if (offset[31:AW+2] != '0) illegal = 1'b1;
`else
        // Without checking, misaligned lane bits are simply dropped
        if (HSIZE == 3'b001) lane_eff = {lane[1], 1'b0};
        else if (HSIZE != 3'b000) lane_eff = 2'b00;
`endif
        case (HSIZE)
            3'b000:  be = 4'b0001 << lane_eff;
            3'b001:  be = 4'b0011 << lane_eff;
            default: be = 4'b1111;
        endcase
    end

    // Outcome of a possible address phase in this cycle
    always_comb begin
        acc_state = StIdle;
        acc_cnt   = 4'd0;
        acc_ready = 1'b1;
        acc_resp  = 2'b00;
        if (accept) begin
`ifdef AHB_SRAM_ERRCHK_EN
            if (illegal) begin
                acc_state = StErr1;
                acc_ready = 1'b0;
                acc_resp  = 2'b01;
            end else
`endif
            begin
                acc_state = StData;
                acc_cnt   = WAIT_INIT;
                acc_ready = (WAIT_INIT == 4'd0);
            end
        end
    end

    // Bus FSM with registered HREADY/HRESP and captured address-phase fields
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            hready_q <= 1'b1;
            hresp_q  <= 2'b00;
            idx_q    <= '0;
            be_q     <= 4'd0;
            write_q  <= 1'b0;
        end else begin
            if (accept) begin
                idx_q   <= idx;
                be_q    <= be;
                write_q <= HWRITE;
            end
            case (state_q)
                StData: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q    <= cnt_q - 4'd1;
                        hready_q <= (cnt_q == 4'd1);
                    end else begin
                        state_q  <= acc_state;
                        cnt_q    <= acc_cnt;
                        hready_q <= acc_ready;
                        hresp_q  <= acc_resp;
                    end
                end
`ifdef AHB_SRAM_ERRCHK_EN
                StErr1: begin
                    state_q  <= StErr2;
                    hready_q <= 1'b1;
                    hresp_q  <= 2'b01;
                end
`endif
                default: begin
                    state_q  <= acc_state;
                    cnt_q    <= acc_cnt;
                    hready_q <= acc_ready;
                    hresp_q  <= acc_resp;
                end
            endcase
        end
    end

    // A write lands on the completing edge of its data phase
    always_comb begin
        commit = (state_q == StData) && (cnt_q == 4'd0) && write_q;
    end

    // Byte-lane write into the array; contents are intentionally not reset
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    // Full word is returned; the master picks the lanes it needs
    always_comb begin
        HRDATA = '0;
        if (state_q == StData && !write_q) HRDATA = mem[idx_q];
    end

    assign HREADY = hready_q;
    assign HRESP  = hresp_q;

`ifdef AHB_SRAM_ERRCHK_EN
    logic unused_inputs;
    assign unused_inputs = ^{HBUST, HTRANS[0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{HBUST, HTRANS[0], offset[31:AW+2], illegal};
`endif

endmodule
